// File: rtl/ddc_pkg.sv
// Shared widths, FSM encoding and width helpers for the DDC mixer/decimator.
package ddc_pkg;
    localparam int ADC_W_DEF = 12;
    localparam int NCO_W_DEF = 16;
    localparam int OUT_W_DEF = 16;
    localparam int DEC_W_DEF = 8;
    localparam int SHIFT_W   = 4;
    localparam int RND_GUARD = 1;
    localparam int SAMT_W    = 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} ddc_state_t;

    function automatic int prod_width(input int adc_w, input int nco_w);
        return adc_w + nco_w;
    endfunction

    function automatic int acc_width(input int adc_w, input int nco_w, input int dec_w);
        return adc_w + nco_w + dec_w;
    endfunction

    // A guard bit keeps the rounding offset from ever wrapping a full-scale sum.
    function automatic int rnd_width(input int acc_w);
        return acc_w + RND_GUARD;
    endfunction
endpackage

// File: rtl/ddc_mixer_decim_if.sv
// Sample/result bus of the DDC: ADC + NCO inputs in, decimated I/Q out.
interface ddc_mixer_decim_if
    import ddc_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic signed [ADC_W-1:0] adc_i;
    logic                    adc_valid;
    logic signed [NCO_W-1:0] nco_sin;
    logic signed [NCO_W-1:0] nco_cos;
    logic                    nco_valid;
    logic signed [OUT_W-1:0] i_o;
    logic signed [OUT_W-1:0] q_o;
    logic                    out_valid;
    logic                    ovf_o;

    modport master (
        output adc_i, adc_valid, nco_sin, nco_cos, nco_valid,
        input  i_o, q_o, out_valid, ovf_o
    );

    modport slave (
        input  adc_i, adc_valid, nco_sin, nco_cos, nco_valid,
        output i_o, q_o, out_valid, ovf_o
    );
endinterface

// File: rtl/ddc_round_sat.sv
// Gain normalisation of one accumulator channel: shift by (ADC_W-1)+shift,
// round half up, saturate to OUT_W and flag the clip.
module ddc_round_sat
    import ddc_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int ACC_W = acc_width(ADC_W_DEF, NCO_W_DEF, DEC_W_DEF),
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic [SHIFT_W-1:0]      shift,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    localparam int RND_W = rnd_width(ACC_W);
    localparam logic signed [RND_W-1:0] MAX_V = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] MIN_V = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [SAMT_W-1:0]       s_amt;
    logic signed [RND_W-1:0] sum_x;
    logic signed [RND_W-1:0] half;
    logic signed [RND_W-1:0] shifted;

    assign s_amt   = SAMT_W'(ADC_W - 1) + SAMT_W'(shift);
    assign sum_x   = {{RND_GUARD{sum[ACC_W-1]}}, sum};
    assign half    = RND_W'(1) << (s_amt - SAMT_W'(1));
    assign shifted = (sum_x + half) >>> s_amt;

    always_comb begin
        y   = shifted[OUT_W-1:0];
        sat = 1'b0;
        if (shifted > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/ddc_mixer_decim.sv
// Digital down-converter back end: mix ADC samples with NCO cos/-sin,
// integrate-and-dump over N products, then round/saturate to OUT_W.
module ddc_mixer_decim
    import ddc_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEC_W = DEC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic [DEC_W-1:0]   dec_n,
    input  logic [SHIFT_W-1:0] dec_shift,
    ddc_mixer_decim_if.slave   bus
);
    localparam int PROD_W = prod_width(ADC_W, NCO_W);
    localparam int ACC_W  = acc_width(ADC_W, NCO_W, DEC_W);
    localparam int NCH    = 2;   // channel 0 = I (cos), channel 1 = Q (-sin)

    logic accept;
    assign accept = clken & bus.adc_valid & bus.nco_valid;

    logic signed [ADC_W-1:0]  adc_reg;
    logic signed [NCO_W-1:0]  nco_reg [NCH];
    logic                     s1_vld_reg;
    logic signed [PROD_W-1:0] adc_x;
    logic signed [PROD_W-1:0] nco_x   [NCH];
    logic signed [PROD_W-1:0] prod    [NCH];
    logic signed [PROD_W-1:0] p_reg   [NCH];
    logic                     s2_vld_reg;

    ddc_state_t               state_reg;
    logic [DEC_W-1:0]         cnt_reg;
    logic [DEC_W-1:0]         n_reg;
    logic [DEC_W-1:0]         n_eff;
    logic [DEC_W-1:0]         cnt_inc;
    logic                     last;
    logic signed [ACC_W-1:0]  acc_reg [NCH];
    logic signed [ACC_W-1:0]  sum     [NCH];
    logic signed [OUT_W-1:0]  rs_y    [NCH];
    logic [NCH-1:0]           rs_sat;
    logic signed [OUT_W-1:0]  out_reg [NCH];
    logic                     out_vld_reg;
    logic                     ovf_reg;

    assign adc_x = {{NCO_W{adc_reg[ADC_W-1]}}, adc_reg};

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign nco_x[gi] = {{ADC_W{nco_reg[gi][NCO_W-1]}}, nco_reg[gi]};
            // PROD_W holds -(-2^(ADC_W-1) * -2^(NCO_W-1)) without wrapping.
            if (gi == 0) begin : g_i
                assign prod[gi] = adc_x * nco_x[gi];
            end else begin : g_q
                assign prod[gi] = -(adc_x * nco_x[gi]);
            end
            assign sum[gi] = acc_reg[gi] + {{DEC_W{p_reg[gi][PROD_W-1]}}, p_reg[gi]};

            ddc_round_sat #(
                .ADC_W (ADC_W),
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_round_sat (
                .sum   (sum[gi]),
                .shift (dec_shift),
                .y     (rs_y[gi]),
                .sat   (rs_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_reg    <= '0;
            s1_vld_reg <= 1'b0;
            s2_vld_reg <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                nco_reg[ch] <= '0;
                p_reg[ch]   <= '0;
            end
        end else if (clken) begin
            s1_vld_reg <= accept;
            s2_vld_reg <= s1_vld_reg;
            if (accept) begin
                adc_reg    <= bus.adc_i;
                nco_reg[0] <= bus.nco_cos;
                nco_reg[1] <= bus.nco_sin;
            end
            if (s1_vld_reg) begin
                for (int ch = 0; ch < NCH; ch++) p_reg[ch] <= prod[ch];
            end
        end
    end

    // The frame length is sampled only while idle so mid-frame dec_n edits wait.
    assign n_eff   = (state_reg == ST_IDLE) ? ((dec_n == '0) ? DEC_W'(1) : dec_n) : n_reg;
    assign cnt_inc = cnt_reg + DEC_W'(1);
    assign last    = (cnt_inc == n_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            n_reg       <= '0;
            out_vld_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                acc_reg[ch] <= '0;
                out_reg[ch] <= '0;
            end
        end else if (clken) begin
            out_vld_reg <= 1'b0;
            if (s2_vld_reg) begin
                if (last) begin
                    state_reg   <= ST_IDLE;
                    cnt_reg     <= '0;
                    out_vld_reg <= 1'b1;
                    ovf_reg     <= ovf_reg | (|rs_sat);
                    for (int ch = 0; ch < NCH; ch++) begin
                        acc_reg[ch] <= '0;
                        out_reg[ch] <= rs_y[ch];
                    end
                end else begin
                    state_reg <= ST_ACCUM;
                    cnt_reg   <= cnt_inc;
                    n_reg     <= n_eff;
                    for (int ch = 0; ch < NCH; ch++) acc_reg[ch] <= sum[ch];
                end
            end
        end
    end

    assign bus.i_o       = out_reg[0];
    assign bus.q_o       = out_reg[1];
    assign bus.out_valid = out_vld_reg & clken;
    assign bus.ovf_o     = ovf_reg;
endmodule

// File: tb/tb_ddc_mixer_decim.sv
// Directed + randomized check of ddc_mixer_decim against a frame-level arithmetic model.
`timescale 1ns/1ps
module tb_ddc_mixer_decim;
    localparam int ADC_W = 12;
    localparam int NCO_W = 16;
    localparam int OUT_W = 16;
    localparam int DEC_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             clken;
    logic [DEC_W-1:0] dec_n;
    logic [3:0]       dec_shift;

    ddc_mixer_decim_if #(.ADC_W(ADC_W), .NCO_W(NCO_W), .OUT_W(OUT_W)) bus_if ();

    ddc_mixer_decim #(
        .ADC_W (ADC_W),
        .NCO_W (NCO_W),
        .OUT_W (OUT_W),
        .DEC_W (DEC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .dec_n     (dec_n),
        .dec_shift (dec_shift),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint i;
        longint q;
        bit     sat;
    } pend_t;

    pend_t  pq[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     ec       = 0;
    int     fr_cnt   = 0;
    int     fr_n     = 1;
    int     pulses   = 0;
    int     accepted = 0;
    longint fr_i     = 0;
    longint fr_q     = 0;
    longint shown_i  = 0;
    longint shown_q  = 0;
    bit     shown_ovf = 1'b0;

    // floor((s + 2^(S-1)) / 2^S) clamped to the output range
    function automatic longint scale(input longint s, input int sh, output bit sat);
        longint d, r, y, hi, lo;
        d  = longint'(1) <<< (ADC_W - 1 + sh);
        r  = s + d / 2;
        y  = r / d;
        if ((r % d != 0) && (r < 0)) y = y - 1;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        sat = 1'b0;
        if (y > hi) begin
            y = hi;
            sat = 1'b1;
        end else if (y < lo) begin
            y = lo;
            sat = 1'b1;
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit ce, input bit av, input bit nv,
                        input logic signed [ADC_W-1:0] a,
                        input logic signed [NCO_W-1:0] s,
                        input logic signed [NCO_W-1:0] c);
        bit    exp_v;
        bit    si, sq;
        pend_t e;
        clken            = ce;
        bus_if.adc_valid = av;
        bus_if.nco_valid = nv;
        bus_if.adc_i     = a;
        bus_if.nco_sin   = s;
        bus_if.nco_cos   = c;
        @(negedge clk);
        exp_v = ce && (pq.size() > 0) && (pq[0].due == ec);
        chk("out_valid", 64'(bus_if.out_valid), 64'(exp_v));
        if (bus_if.out_valid === 1'b1) pulses++;
        if (exp_v) void'(pq.pop_front());
        chk("i_o", 64'(bus_if.i_o), shown_i);
        chk("q_o", 64'(bus_if.q_o), shown_q);
        chk("ovf_o", 64'(bus_if.ovf_o), 64'(shown_ovf));
        @(posedge clk);
        if (ce) begin
            if (av && nv) begin
                accepted++;
                if (fr_cnt == 0) fr_n = (dec_n == '0) ? 1 : int'(dec_n);
                fr_i += longint'(a) * longint'(c);
                fr_q -= longint'(a) * longint'(s);
                fr_cnt++;
                if (fr_cnt == fr_n) begin
                    e.due = ec + 3;
                    e.i   = scale(fr_i, int'(dec_shift), si);
                    e.q   = scale(fr_q, int'(dec_shift), sq);
                    e.sat = si | sq;
                    pq.push_back(e);
                    fr_cnt = 0;
                    fr_i   = 0;
                    fr_q   = 0;
                end
            end
            if ((pq.size() > 0) && (pq[0].due == ec + 1)) begin
                shown_i   = pq[0].i;
                shown_q   = pq[0].q;
                shown_ovf = shown_ovf | pq[0].sat;
            end
            ec++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_accept(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b1, 12'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic do_reset(input int cycles, input bit ce);
        reset            = 1'b1;
        clken            = ce;
        bus_if.adc_valid = 1'b1;
        bus_if.nco_valid = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset            = 1'b0;
        clken            = 1'b0;
        bus_if.adc_valid = 1'b0;
        bus_if.nco_valid = 1'b0;
        pq.delete();
        fr_cnt = 0;
        fr_i = 0;
        fr_q = 0;
        shown_i = 0;
        shown_q = 0;
        shown_ovf = 1'b0;
        chk("rst_i_o", 64'(bus_if.i_o), 64'sd0);
        chk("rst_q_o", 64'(bus_if.q_o), 64'sd0);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'sd0);
        chk("rst_ovf_o", 64'(bus_if.ovf_o), 64'sd0);
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b0;
        dec_n = 8'd1;
        dec_shift = 4'd0;
        bus_if.adc_i = '0;
        bus_if.adc_valid = 1'b0;
        bus_if.nco_sin = '0;
        bus_if.nco_cos = '0;
        bus_if.nco_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3, 1'b0);

        // N=1, unity scaling: one result per accepted sample
        dec_n = 8'd1;
        dec_shift = 4'd0;
        pulses = 0;
        repeat (10) step(1'b1, 1'b1, 1'b1, 12'sd1024, 16'sd0, 16'sd32767);
        idle(4);
        chk("n1_i_o", 64'(bus_if.i_o), 64'sd16384);
        chk("n1_q_o", 64'(bus_if.q_o), 64'sd0);
        chk("n1_pulses", 64'(pulses), 64'sd10);

        // N=4, shift 2, near full scale on both channels
        dec_n = 8'd4;
        dec_shift = 4'd2;
        pulses = 0;
        repeat (16) step(1'b1, 1'b1, 1'b1, 12'sd2047, 16'sh8000, 16'sd32767);
        idle(4);
        chk("n4_i_o", 64'(bus_if.i_o), 64'sd32751);
        chk("n4_q_o", 64'(bus_if.q_o), 64'sd32752);
        chk("n4_ovf", 64'(bus_if.ovf_o), 64'sd0);
        chk("n4_pulses", 64'(pulses), 64'sd4);

        // Positive saturation and sticky overflow
        dec_shift = 4'd0;
        repeat (4) step(1'b1, 1'b1, 1'b1, 12'sh800, 16'sd0, 16'sh8000);
        idle(6);
        chk("sat_i_o", 64'(bus_if.i_o), 64'sd32767);
        chk("sat_ovf", 64'(bus_if.ovf_o), 64'sd1);
        repeat (4) step(1'b1, 1'b1, 1'b1, 12'sd1, 16'sd0, 16'sd1);
        idle(4);
        chk("sat_ovf_sticky", 64'(bus_if.ovf_o), 64'sd1);

        // N=3 with random gaps on clken and both valids
        do_reset(1, 1'b1);
        dec_n = 8'd3;
        dec_shift = 4'($urandom_range(0, 3));
        pulses = 0;
        accepted = 0;
        repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          12'($urandom), 16'($urandom), 16'($urandom));
        idle(8);
        chk("gap_pulses", 64'(pulses), 64'(accepted / 3));

        // Reset mid-frame drops the partial sum
        do_reset(2, 1'b1);
        dec_n = 8'd4;
        dec_shift = 4'd1;
        pulses = 0;
        rand_accept(2);
        do_reset(1, 1'b1);
        rand_accept(4);
        idle(5);
        chk("midrst_pulses", 64'(pulses), 64'sd1);

        // dec_n = 0 acts as 1
        dec_n = 8'd0;
        dec_shift = 4'd0;
        pulses = 0;
        rand_accept(5);
        idle(4);
        chk("n0_pulses", 64'(pulses), 64'sd5);

        // dec_n 4 -> 2 mid-frame: this frame closes at 4, later ones at 2
        dec_n = 8'd4;
        pulses = 0;
        rand_accept(2);
        idle(3);
        dec_n = 8'd2;
        rand_accept(6);
        idle(4);
        chk("n4to2_pulses", 64'(pulses), 64'sd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ddc_mixer_decim.md
DDC_MIXER_DECIM -- requirements
Module: ddc_mixer_decim

Interface
REQ-001 Parameter ADC_W, default 12: signed ADC sample width.
REQ-002 Parameter NCO_W, default 16: signed NCO sin/cos width, matching NCO fsin_o/fcos_o.
REQ-003 Parameter OUT_W, default 16: signed I/Q output width.
REQ-004 Parameter DEC_W, default 8: decimation-factor width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clken  in  1  clock enable; low freezes every register.
REQ-008 adc_i  in  ADC_W  signed ADC sample.
REQ-009 adc_valid  in  1  adc_i valid this cycle.
REQ-010 nco_sin  in  NCO_W  signed NCO sine (from NCO fsin_o).
REQ-011 nco_cos  in  NCO_W  signed NCO cosine (from NCO fcos_o).
REQ-012 nco_valid  in  1  NCO out_valid.
REQ-013 dec_n  in  DEC_W  decimation factor 1..255; 0 treated as 1.
REQ-014 dec_shift  in  4  extra right shift for gain normalisation, 0..15.
REQ-015 i_o  out  OUT_W  signed in-phase output.
REQ-016 q_o  out  OUT_W  signed quadrature output.
REQ-017 out_valid  out  1  one-cycle pulse, i_o/q_o valid.
REQ-018 ovf_o  out  1  sticky saturation flag.

Function
REQ-019 Sample accepted iff clken & adc_valid & nco_valid; unaccepted cycles do not affect accumulators or counters.
REQ-020 Stage 1 registers accepted adc_i, nco_sin, nco_cos, plus an accept flag.
REQ-021 Stage 2 computes full-precision products: pI = adc*cos, pQ = -(adc*sin); width ADC_W+NCO_W (28); -(-2048*-32768) is representable, with no wrap.
REQ-022 Stage 3 is an accumulator of width ADC_W+NCO_W+DEC_W (36) per channel, sign-extended adds.
REQ-023 States: IDLE (no samples accumulated) and ACCUM (frame in progress); IDLE->ACCUM on the first accepted product; ACCUM->IDLE on dump.
REQ-024 Frame length N is latched from dec_n (0->1) at the first product of each frame; dec_n changes mid-frame take effect next frame.
REQ-025 Dump occurs when the N-th product of the frame is added: the output is the sum including that product, and the accumulator restarts from zero (no lost sample if the next product arrives the following cycle).
REQ-026 Output scaling: S = (ADC_W-1)+dec_shift; result = (sum + 2^(S-1)) >>> S (round half up), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 Saturation on either channel sets ovf_o; ovf_o is cleared only by reset.
REQ-028 Latency: out_valid asserts exactly 3 enabled cycles after the cycle in which the N-th sample is accepted.
REQ-029 out_valid is high one cycle per dump, is forced 0 while clken is low, and i_o/q_o hold their values between dumps.
REQ-030 Sustained throughput: one accepted sample per cycle with no stalls.

Reset
REQ-031 reset (sync) clears the pipeline, accumulators, counter, latched N, and state to IDLE; i_o=0, q_o=0, out_valid=0, ovf_o=0.
REQ-032 reset mid-frame discards the partial sum; no out_valid is produced for that frame.
REQ-033 reset takes priority over clken.

Structure
REQ-034 ADC_W, NCO_W, OUT_W, DEC_W defaults and the rounding/saturation width constants SHALL reside in shared package ddc_pkg.
REQ-035 One sub-module, ddc_round_sat (shift, round, saturate, overflow flag), is instantiated once per channel.

Verification
REQ-036 dec_n=1, dec_shift=0, adc=1024, cos=32767, sin=0 -> i_o=16384, q_o=0, out_valid 3 cycles after each accepted sample.
REQ-037 dec_n=4, dec_shift=2, adc=2047, cos=32767, sin=-32768, continuous -> i_o=32751, q_o=32752, one pulse per 4 samples, ovf_o=0.
REQ-038 dec_n=4, dec_shift=0, adc=-2048, cos=-32768, sin=0 -> i_o=32767 (saturated), ovf_o=1 stays set afterwards.
REQ-039 dec_n=3, adc_valid/nco_valid/clken randomly gapped -> exactly one pulse per 3 accepted samples, sums match the model.
REQ-040 dec_n=4, reset after 2 accepted samples -> no pulse; the next 4 samples produce a clean frame equal to the model.
REQ-041 dec_n=0 -> behaves as 1; changing dec_n 4->2 mid-frame -> the current frame completes at 4 and the next at 2.
